// File: rtl/button_event_conditioner.sv
// Per-channel push-button conditioner: two-flop synchroniser, debounce, selectable edge event
// held until acknowledged, sticky overrun flag and a one-shot long-press pulse.
module button_event_conditioner #(
  parameter int CHANNELS   = 4,
  parameter int DEBOUNCE   = 4,
  parameter int EDGE_MODE  = 0,
  parameter int LONG_PRESS = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] btn_i,
  input  logic [CHANNELS-1:0] ack_i,
  output logic [CHANNELS-1:0] stable_o,
  output logic [CHANNELS-1:0] pending_o,
  output logic [CHANNELS-1:0] overrun_o,
  output logic [CHANNELS-1:0] long_o
);

  localparam int DW = $clog2(DEBOUNCE + 1);
  localparam int LW = $clog2(LONG_PRESS + 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE - 1);
  localparam logic [LW-1:0] LONG_MAX = LW'(LONG_PRESS);
  localparam logic EV_RISE = (EDGE_MODE != 1'b0 ? 1'b1 : 1'b0) && (EDGE_MODE != 0);
  localparam logic EV_FALL = (EDGE_MODE != 1);

  logic [CHANNELS-1:0] sync1;
  logic [CHANNELS-1:0] sync2;
  logic [CHANNELS-1:0] accept;
  logic [CHANNELS-1:0] evt;
  logic [CHANNELS-1:0] longFired;
  logic [DW-1:0]       debCnt  [CHANNELS];
  logic [LW-1:0]       longCnt [CHANNELS];

  // Acceptance and event qualification, evaluated against the level about to be replaced
  always_comb begin
    accept = '0;
    evt    = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if ((sync2[c] != stable_o[c]) && (debCnt[c] == DEB_LAST)) begin
        accept[c] = 1'b1;
      end else begin
        accept[c] = 1'b0;
      end
    end
    evt = accept & ((~stable_o & {CHANNELS{EV_RISE}}) | (stable_o & {CHANNELS{EV_FALL}}));
  end

  // Synchroniser, debounce and event/acknowledge handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1     <= '0;
      sync2     <= '0;
      stable_o  <= '0;
      pending_o <= '0;
      overrun_o <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        debCnt[c] <= '0;
      end
    end else begin
      sync1 <= btn_i;
      sync2 <= sync1;
      for (int c = 0; c < CHANNELS; c++) begin
        if (sync2[c] == stable_o[c]) begin
          debCnt[c] <= '0;
        end else if (accept[c]) begin
          debCnt[c]   <= '0;
          stable_o[c] <= sync2[c];
        end else begin
          debCnt[c] <= debCnt[c] + DW'(1);
        end
        // A fresh event wins over a simultaneous ack and replaces the acked one
        if (evt[c]) begin
          pending_o[c] <= 1'b1;
        end else if (ack_i[c]) begin
          pending_o[c] <= 1'b0;
        end
        if (evt[c] && pending_o[c] && !ack_i[c]) begin
          overrun_o[c] <= 1'b1;
        end
      end
    end
  end

  // Long-press timer: pulses the cycle after the counter saturates, once per press
  always_ff @(posedge clk) begin
    if (rst) begin
      long_o    <= '0;
      longFired <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        longCnt[c] <= '0;
      end
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (!stable_o[c]) begin
          longCnt[c]   <= '0;
          longFired[c] <= 1'b0;
          long_o[c]    <= 1'b0;
        end else begin
          if (longCnt[c] != LONG_MAX) begin
            longCnt[c] <= longCnt[c] + LW'(1);
          end
          long_o[c] <= (longCnt[c] == LONG_MAX) && !longFired[c];
          if (longCnt[c] == LONG_MAX) begin
            longFired[c] <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_button_event_conditioner.sv
// Directed bench for button_event_conditioner: a both-edge instance drives most checks,
// a release-only instance covers edge selection and ack of an idle channel.
module tb_button_event_conditioner;

  logic       clk;
  logic       rst;
  logic [1:0] btn;
  logic [1:0] ack;
  logic [1:0] stable;
  logic [1:0] pending;
  logic [1:0] overrun;
  logic [1:0] longP;
  logic [1:0] btnB;
  logic [1:0] ackB;
  logic [1:0] stableB;
  logic [1:0] pendingB;
  logic [1:0] overrunB;
  logic [1:0] longB;

  int total = 0;
  int bad   = 0;

  button_event_conditioner #(
    .CHANNELS(2), .DEBOUNCE(4), .EDGE_MODE(2), .LONG_PRESS(8)
  ) dut (
    .clk(clk), .rst(rst), .btn_i(btn), .ack_i(ack),
    .stable_o(stable), .pending_o(pending), .overrun_o(overrun), .long_o(longP)
  );

  button_event_conditioner #(
    .CHANNELS(2), .DEBOUNCE(4), .EDGE_MODE(0), .LONG_PRESS(8)
  ) dutRel (
    .clk(clk), .rst(rst), .btn_i(btnB), .ack_i(ackB),
    .stable_o(stableB), .pending_o(pendingB), .overrun_o(overrunB), .long_o(longB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkEq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst = 1'b1; btn = 2'b00; ack = 2'b00; btnB = 2'b00; ackB = 2'b00;
    tick(2);
    checkEq("rst_stable",  {6'd0, stable},  8'h00);
    checkEq("rst_pending", {6'd0, pending}, 8'h00);
    checkEq("rst_overrun", {6'd0, overrun}, 8'h00);
    checkEq("rst_long",    {6'd0, longP},   8'h00);
    rst = 1'b0;

    // clean press on ch0: accepted at edge 5 (6th edge after the change)
    btn = 2'b01;
    tick(5);
    checkEq("press_early_stable",  {6'd0, stable},  8'h00);
    checkEq("press_early_pending", {6'd0, pending}, 8'h00);
    tick(1);
    checkEq("press_stable",  {6'd0, stable},  8'h01);
    checkEq("press_pending", {6'd0, pending}, 8'h01);
    ack = 2'b01; tick(1); ack = 2'b00;
    checkEq("ack_clears", {6'd0, pending}, 8'h00);
    btn = 2'b00;
    tick(6);
    checkEq("release_stable",  {6'd0, stable},  8'h00);
    checkEq("release_pending", {6'd0, pending}, 8'h01);
    ack = 2'b01; tick(1); ack = 2'b00;
    checkEq("ack_release", {6'd0, pending}, 8'h00);

    // 3-cycle glitch is filtered
    btn = 2'b01; tick(3); btn = 2'b00;
    tick(8);
    checkEq("glitch3_stable",  {6'd0, stable},  8'h00);
    checkEq("glitch3_pending", {6'd0, pending}, 8'h00);

    // 4-cycle glitch is accepted, then its release follows at edge 9
    btn = 2'b01; tick(4); btn = 2'b00;
    tick(2);
    checkEq("glitch4_stable",  {6'd0, stable},  8'h01);
    checkEq("glitch4_pending", {6'd0, pending}, 8'h01);
    ack = 2'b01; tick(1); ack = 2'b00;
    checkEq("glitch4_ack", {6'd0, pending}, 8'h00);
    tick(3);
    checkEq("glitch4_rel_stable",  {6'd0, stable},  8'h00);
    checkEq("glitch4_rel_pending", {6'd0, pending}, 8'h01);
    checkEq("glitch4_no_overrun",  {6'd0, overrun}, 8'h00);
    ack = 2'b01; tick(1); ack = 2'b00;

    // ack exactly at the release-acceptance edge: no overrun
    btn = 2'b01; tick(6);
    checkEq("ackedge_press", {6'd0, pending}, 8'h01);
    btn = 2'b00; tick(5);
    ack = 2'b01; tick(1); ack = 2'b00;
    checkEq("ackedge_stable",  {6'd0, stable},  8'h00);
    checkEq("ackedge_pending", {6'd0, pending}, 8'h01);
    checkEq("ackedge_overrun", {6'd0, overrun}, 8'h00);

    // unacked press then release: overrun
    btn = 2'b01; tick(6);
    btn = 2'b00; tick(6);
    checkEq("overrun_pending", {6'd0, pending}, 8'h01);
    checkEq("overrun_set",     {6'd0, overrun}, 8'h01);

    // reset mid-press with pending and overrun high
    btn = 2'b01; tick(6);
    checkEq("midpress_stable", {6'd0, stable}, 8'h01);
    rst = 1'b1; btn = 2'b00; tick(1);
    checkEq("midrst_all", {stable, pending, overrun, longP}, 8'h00);
    rst = 1'b0; tick(10);
    checkEq("postrst_all", {stable, pending, overrun, longP}, 8'h00);

    // long press on ch1: pulse 9 edges after stable rises, one cycle only
    btn = 2'b10; tick(6);
    checkEq("long_stable", {6'd0, stable}, 8'h02);
    tick(8);
    checkEq("long_before", {6'd0, longP}, 8'h00);
    tick(1);
    checkEq("long_pulse", {6'd0, longP}, 8'h02);
    tick(1);
    checkEq("long_after", {6'd0, longP}, 8'h00);
    tick(6);
    checkEq("long_once", {6'd0, longP}, 8'h00);
    btn = 2'b00; tick(6);
    checkEq("long_release", {6'd0, stable}, 8'h00);
    checkEq("long_rel_overrun", {6'd0, overrun}, 8'h02);
    btn = 2'b10; tick(6 + 8);
    checkEq("long2_before", {6'd0, longP}, 8'h00);
    tick(1);
    checkEq("long2_pulse", {6'd0, longP}, 8'h02);
    btn = 2'b00; tick(8);

    // release-only instance
    ackB = 2'b01; tick(1); ackB = 2'b00;
    checkEq("relmode_idle_ack", {pendingB, overrunB}, 8'h00);
    btnB = 2'b01; tick(6);
    checkEq("relmode_press_stable",  {6'd0, stableB},  8'h01);
    checkEq("relmode_press_pending", {6'd0, pendingB}, 8'h00);
    btnB = 2'b00; tick(6);
    checkEq("relmode_rel_stable",  {6'd0, stableB},  8'h00);
    checkEq("relmode_rel_pending", {6'd0, pendingB}, 8'h01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
